// File: rtl/ovc_allocator_if.sv
// ovc_allocator_if
//   Bundles the allocator's handshake, release, credit and status signals.
//   master: the side driving requests, sends and credit returns (router
//           datapath / input VC buffers).
//   slave : the allocator itself.
//   Signals:
//     req        requesting input VCs (bit per input VC)
//     grant      one-hot grant pulse back to the input VCs
//     grant_ovc  output VC bound by the current grant
//     flit_sent  a flit left on output VC sent_ovc
//     sent_last  that flit was tail/single; releases the output VC
//     credit_in  one downstream credit returned for credit_ovc
//     credit     packed per-output-VC credit counters
//     ovc_busy   per-output-VC allocated flags
//     err        sticky protocol error
interface ovc_allocator_if #(
    parameter int unsigned NUM_IVC = 20,
    parameter int unsigned NUM_OVC = 4,
    parameter int unsigned OVC_W   = 2,
    parameter int unsigned CRED_W  = 3
);
    logic [NUM_IVC-1:0]        req;
    logic [NUM_IVC-1:0]        grant;
    logic [OVC_W-1:0]          grant_ovc;
    logic                      flit_sent;
    logic [OVC_W-1:0]          sent_ovc;
    logic                      sent_last;
    logic                      credit_in;
    logic [OVC_W-1:0]          credit_ovc;
    logic [NUM_OVC*CRED_W-1:0] credit;
    logic [NUM_OVC-1:0]        ovc_busy;
    logic                      err;

    modport master (
        output req, flit_sent, sent_ovc, sent_last, credit_in, credit_ovc,
        input  grant, grant_ovc, credit, ovc_busy, err
    );

    modport slave (
        input  req, flit_sent, sent_ovc, sent_last, credit_in, credit_ovc,
        output grant, grant_ovc, credit, ovc_busy, err
    );
endinterface

// File: rtl/ovc_allocator.sv
// ovc_allocator
//   Per-output-port virtual-channel allocator and downstream credit tracker.
//   Round-robin arbitration among input VCs waiting for an output VC on this
//   port; each winner is bound to the lowest free output VC until its
//   tail/single flit leaves. One credit counter per output VC.
//
//   Ports:
//     clk  clock
//     rst  synchronous, active-high reset
//     bus  ovc_allocator_if.slave: req/grant/grant_ovc handshake,
//          flit_sent/sent_ovc/sent_last release, credit_in/credit_ovc
//          returns, credit/ovc_busy/err status. All outputs are registered.
//
//   Build option:
//     OVC_DRAIN_CHECK_EN  when defined, a free output VC is allocatable only
//                         once its credit has returned to CREDIT_MAX
//                         (downstream fully drained). Undefined: any free
//                         output VC is allocatable.
module ovc_allocator #(
    parameter int unsigned NUM_IVC    = 20,
    parameter int unsigned IVC_W      = 5,
    parameter int unsigned NUM_OVC    = 4,
    parameter int unsigned OVC_W      = 2,
    parameter int unsigned CREDIT_MAX = 4,
    parameter int unsigned CRED_W     = 3
) (
    input  logic           clk,
    input  logic           rst,
    ovc_allocator_if.slave bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_OVC-1:0] busy_q;
    logic [IVC_W-1:0]   owner_q [NUM_OVC];
    logic [CRED_W-1:0]  cred_q  [NUM_OVC];
    logic [IVC_W-1:0]   rr_q;
    logic [NUM_IVC-1:0] grant_q;
    logic [OVC_W-1:0]   grant_ovc_q;
    logic               err_q;

    // ------------------------------------------------------------------
    // Next-state / combinational signals
    // ------------------------------------------------------------------
    logic [NUM_IVC-1:0] owned;
    logic [NUM_IVC-1:0] eligible;
    logic [NUM_OVC-1:0] alloc_ok;
    logic               free_found;
    logic [OVC_W-1:0]   free_idx;
    logic               win_found;
    logic [IVC_W-1:0]   win_idx;
    int unsigned        cand;
    logic               do_alloc;
    logic [IVC_W-1:0]   rr_d;
    logic [NUM_IVC-1:0] grant_d;
    logic [NUM_OVC-1:0] busy_d;
    logic [NUM_OVC-1:0] snd;
    logic [NUM_OVC-1:0] ret;
    logic [NUM_OVC-1:0] underflow;
    logic [NUM_OVC-1:0] overflow;
    logic [CRED_W-1:0]  cred_d [NUM_OVC];
    logic               send_on_free;

    // Requesters already holding an output VC are masked so a requester
    // still dropping req after its grant cannot be granted twice.
    always_comb begin
        owned = '0;
        for (int unsigned i = 0; i < NUM_IVC; i++) begin
            for (int unsigned k = 0; k < NUM_OVC; k++) begin
                if (busy_q[k] && (owner_q[k] == IVC_W'(i))) begin
                    owned[i] = 1'b1;
                end
            end
        end
        eligible = bus.req & ~owned;
    end

    // Allocatable output VCs; the lowest index wins. Uses the registered
    // busy bits, so a VC released at this edge is not reused until the next.
    always_comb begin
        for (int unsigned k = 0; k < NUM_OVC; k++) begin
`ifdef OVC_DRAIN_CHECK_EN
            alloc_ok[k] = !busy_q[k] && (cred_q[k] == CRED_W'(CREDIT_MAX));
`else
            alloc_ok[k] = !busy_q[k];
`endif
        end
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned k = 0; k < NUM_OVC; k++) begin
            if (!free_found && alloc_ok[k]) begin
                free_found = 1'b1;
                free_idx   = OVC_W'(k);
            end
        end
    end

    // Round-robin search: first eligible requester at or above rr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned off = 0; off < NUM_IVC; off++) begin
            cand = int'(rr_q) + off;
            if (cand >= NUM_IVC) begin
                cand = cand - NUM_IVC;
            end
            if (!win_found && eligible[IVC_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IVC_W'(cand);
            end
        end
    end

    always_comb begin
        do_alloc = win_found && free_found;
        rr_d     = (win_idx == IVC_W'(NUM_IVC - 1)) ? '0 : win_idx + IVC_W'(1);
        grant_d  = '0;
        if (do_alloc) begin
            grant_d[win_idx] = 1'b1;
        end
    end

    // Busy: release first, then allocation. They never target the same VC
    // unless a send hits a free VC, in which case the new binding wins.
    always_comb begin
        busy_d = busy_q;
        if (bus.flit_sent && bus.sent_last) begin
            busy_d[bus.sent_ovc] = 1'b0;
        end
        if (do_alloc) begin
            busy_d[free_idx] = 1'b1;
        end
        send_on_free = bus.flit_sent && !busy_q[bus.sent_ovc];
    end

    // Credits: a simultaneous send and return cancel out; saturate at both
    // ends and flag the error instead of wrapping.
    always_comb begin
        for (int unsigned k = 0; k < NUM_OVC; k++) begin
            snd[k]       = bus.flit_sent && (bus.sent_ovc == OVC_W'(k));
            ret[k]       = bus.credit_in && (bus.credit_ovc == OVC_W'(k));
            cred_d[k]    = cred_q[k];
            underflow[k] = 1'b0;
            overflow[k]  = 1'b0;
            if (snd[k] && !ret[k]) begin
                if (cred_q[k] == '0) begin
                    underflow[k] = 1'b1;
                end else begin
                    cred_d[k] = cred_q[k] - CRED_W'(1);
                end
            end else if (ret[k] && !snd[k]) begin
                if (cred_q[k] == CRED_W'(CREDIT_MAX)) begin
                    overflow[k] = 1'b1;
                end else begin
                    cred_d[k] = cred_q[k] + CRED_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            rr_q        <= '0;
            grant_q     <= '0;
            grant_ovc_q <= '0;
            err_q       <= 1'b0;
            for (int unsigned k = 0; k < NUM_OVC; k++) begin
                owner_q[k] <= '0;
                cred_q[k]  <= CRED_W'(CREDIT_MAX);
            end
        end else begin
            busy_q  <= busy_d;
            grant_q <= grant_d;
            err_q   <= err_q | (|underflow) | (|overflow) | send_on_free;
            for (int unsigned k = 0; k < NUM_OVC; k++) begin
                cred_q[k] <= cred_d[k];
            end
            if (do_alloc) begin
                grant_ovc_q       <= free_idx;
                owner_q[free_idx] <= win_idx;
                rr_q              <= rr_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.credit = '0;
        for (int unsigned k = 0; k < NUM_OVC; k++) begin
            bus.credit[k*CRED_W +: CRED_W] = cred_q[k];
        end
    end

    assign bus.grant     = grant_q;
    assign bus.grant_ovc = grant_ovc_q;
    assign bus.ovc_busy  = busy_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_ovc_allocator.sv
// tb_ovc_allocator
//   Self-checking bench for ovc_allocator. Directed scenarios plus a random
//   phase, all compared against a behavioural model of the allocator kept
//   as plain integer arrays.
module tb_ovc_allocator;

    localparam int NUM_IVC    = 20;
    localparam int IVC_W      = 5;
    localparam int NUM_OVC    = 4;
    localparam int OVC_W      = 2;
    localparam int CREDIT_MAX = 4;
    localparam int CRED_W     = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ovc_allocator_if #(.NUM_IVC(NUM_IVC), .NUM_OVC(NUM_OVC), .OVC_W(OVC_W), .CRED_W(CRED_W)) bus ();

    ovc_allocator #(
        .NUM_IVC(NUM_IVC), .IVC_W(IVC_W), .NUM_OVC(NUM_OVC), .OVC_W(OVC_W),
        .CREDIT_MAX(CREDIT_MAX), .CRED_W(CRED_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    int               m_busy  [NUM_OVC];
    int               m_owner [NUM_OVC];
    int               m_cred  [NUM_OVC];
    int               m_rr;
    int               m_gvc;
    bit               m_err;
    logic [NUM_IVC-1:0] m_grant;

    task automatic model_reset();
        for (int k = 0; k < NUM_OVC; k++) begin
            m_busy[k] = 0; m_owner[k] = 0; m_cred[k] = CREDIT_MAX;
        end
        m_rr = 0; m_gvc = 0; m_err = 0; m_grant = '0;
    endtask

    // One clock edge of the allocator's rules, applied to current inputs.
    task automatic model_edge();
        int fk, win, idx;
        int nb [NUM_OVC];
        bit ok, mine, s, r;
        if (rst) begin
            model_reset();
            return;
        end
        fk = -1;
        for (int k = 0; k < NUM_OVC; k++) begin
            ok = (m_busy[k] == 0);
`ifdef OVC_DRAIN_CHECK_EN
            ok = ok && (m_cred[k] == CREDIT_MAX);
`endif
            if (ok && fk < 0) fk = k;
        end
        win = -1;
        for (int off = 0; off < NUM_IVC; off++) begin
            idx = (m_rr + off) % NUM_IVC;
            mine = 0;
            for (int k = 0; k < NUM_OVC; k++)
                if (m_busy[k] != 0 && m_owner[k] == idx) mine = 1;
            if (win < 0 && bus.req[idx] && !mine) win = idx;
        end
        for (int k = 0; k < NUM_OVC; k++) nb[k] = m_busy[k];
        if (bus.flit_sent) begin
            if (m_busy[int'(bus.sent_ovc)] == 0) m_err = 1;
            if (bus.sent_last) nb[int'(bus.sent_ovc)] = 0;
        end
        for (int k = 0; k < NUM_OVC; k++) begin
            s = bus.flit_sent && (int'(bus.sent_ovc) == k);
            r = bus.credit_in && (int'(bus.credit_ovc) == k);
            if (s && !r) begin
                if (m_cred[k] == 0) m_err = 1; else m_cred[k] = m_cred[k] - 1;
            end else if (r && !s) begin
                if (m_cred[k] == CREDIT_MAX) m_err = 1; else m_cred[k] = m_cred[k] + 1;
            end
        end
        m_grant = '0;
        if (win >= 0 && fk >= 0) begin
            m_grant[win] = 1'b1;
            m_gvc        = fk;
            nb[fk]       = 1;
            m_owner[fk]  = win;
            m_rr         = (win + 1) % NUM_IVC;
        end
        for (int k = 0; k < NUM_OVC; k++) m_busy[k] = nb[k];
    endtask

    function automatic logic [NUM_OVC-1:0] m_busy_vec();
        logic [NUM_OVC-1:0] v;
        for (int k = 0; k < NUM_OVC; k++) v[k] = (m_busy[k] != 0);
        return v;
    endfunction

    function automatic logic [NUM_OVC*CRED_W-1:0] m_cred_vec();
        logic [NUM_OVC*CRED_W-1:0] v;
        for (int k = 0; k < NUM_OVC; k++) v[k*CRED_W +: CRED_W] = CRED_W'(m_cred[k]);
        return v;
    endfunction

    // Inputs are changed #1 after the edge, outputs sampled there too.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req = '0; bus.flit_sent = 1'b0; bus.sent_ovc = '0; bus.sent_last = 1'b0;
        bus.credit_in = 1'b0; bus.credit_ovc = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    // Release output VC k with its credit returned in the same cycle.
    task automatic release_ovc(input int k);
        bus.flit_sent = 1'b1; bus.sent_ovc = OVC_W'(k); bus.sent_last = 1'b1;
        bus.credit_in = 1'b1; bus.credit_ovc = OVC_W'(k);
        cycle();
        bus.flit_sent = 1'b0; bus.sent_last = 1'b0; bus.credit_in = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cycle(); cycle();
        rst = 1'b0;
        repeat (3) cycle();
        tests_run++;
        if (bus.grant !== '0) begin
            tests_failed++; $display("FAIL reset_grant got=%h want=0", bus.grant);
        end
        tests_run++;
        if (bus.ovc_busy !== '0) begin
            tests_failed++; $display("FAIL reset_busy got=%b want=0000", bus.ovc_busy);
        end
        for (int k = 0; k < NUM_OVC; k++) begin
            tests_run++;
            if (bus.credit[k*CRED_W +: CRED_W] !== CRED_W'(CREDIT_MAX)) begin
                tests_failed++;
                $display("FAIL reset_credit%0d got=%0d want=%0d", k, bus.credit[k*CRED_W +: CRED_W], CREDIT_MAX);
            end
        end
        tests_run++;
        if (bus.err !== 1'b0) begin
            tests_failed++; $display("FAIL reset_err got=%b want=0", bus.err);
        end
    endtask

    task automatic test_single_hold();
        do_reset();
        bus.req = NUM_IVC'(1) << 3;
        cycle();
        tests_run++;
        if (bus.grant !== (NUM_IVC'(1) << 3) || bus.grant_ovc !== OVC_W'(0) || bus.ovc_busy !== 4'b0001) begin
            tests_failed++;
            $display("FAIL hold_first grant=%h ovc=%0d busy=%b want grant=%h ovc=0 busy=0001",
                     bus.grant, bus.grant_ovc, bus.ovc_busy, NUM_IVC'(1) << 3);
        end
        for (int c = 0; c < 3; c++) begin
            cycle();
            tests_run++;
            if (bus.grant !== '0 || bus.ovc_busy !== 4'b0001) begin
                tests_failed++;
                $display("FAIL hold_regrant c=%0d grant=%h busy=%b want grant=0 busy=0001", c, bus.grant, bus.ovc_busy);
            end
        end
        bus.req = '0;
        release_ovc(0);
        tests_run++;
        if (bus.ovc_busy !== 4'b0000 || bus.credit[CRED_W-1:0] !== CRED_W'(CREDIT_MAX)) begin
            tests_failed++;
            $display("FAIL hold_release busy=%b cred0=%0d want busy=0000 cred0=4", bus.ovc_busy, bus.credit[CRED_W-1:0]);
        end
    endtask

    task automatic test_back_to_back();
        int exp_i [3];
        exp_i = '{2, 5, 7};
        do_reset();
        bus.req = (NUM_IVC'(1) << 2) | (NUM_IVC'(1) << 5) | (NUM_IVC'(1) << 7);
        for (int n = 0; n < 3; n++) begin
            cycle();
            tests_run++;
            if (bus.grant !== (NUM_IVC'(1) << exp_i[n]) || bus.grant_ovc !== OVC_W'(n)) begin
                tests_failed++;
                $display("FAIL b2b_grant%0d grant=%h ovc=%0d want grant=%h ovc=%0d",
                         n, bus.grant, bus.grant_ovc, NUM_IVC'(1) << exp_i[n], n);
            end
        end
        bus.req = '0;
        release_ovc(0); release_ovc(1); release_ovc(2);
        // rr is now 8: requester 9 must beat requester 1
        bus.req = (NUM_IVC'(1) << 1) | (NUM_IVC'(1) << 9);
        cycle();
        tests_run++;
        if (bus.grant !== (NUM_IVC'(1) << 9) || bus.grant !== m_grant) begin
            tests_failed++;
            $display("FAIL rr_after_b2b grant=%h want=%h", bus.grant, NUM_IVC'(1) << 9);
        end
        cycle();
        tests_run++;
        if (bus.grant !== (NUM_IVC'(1) << 1) || bus.grant_ovc !== OVC_W'(1)) begin
            tests_failed++;
            $display("FAIL rr_second grant=%h ovc=%0d want grant=%h ovc=1", bus.grant, bus.grant_ovc, NUM_IVC'(1) << 1);
        end
        bus.req = '0;
    endtask

    task automatic test_full_release();
        do_reset();
        bus.req = NUM_IVC'(5'b11111);
        repeat (4) cycle();
        cycle();
        tests_run++;
        if (bus.grant !== '0 || bus.ovc_busy !== 4'b1111) begin
            tests_failed++;
            $display("FAIL full_wait grant=%h busy=%b want grant=0 busy=1111", bus.grant, bus.ovc_busy);
        end
        bus.req[1] = 1'b0;
        bus.flit_sent = 1'b1; bus.sent_ovc = OVC_W'(1); bus.sent_last = 1'b1;
        cycle();
        bus.flit_sent = 1'b0; bus.sent_last = 1'b0;
        tests_run++;
        if (bus.grant !== '0 || bus.ovc_busy !== 4'b1101) begin
            tests_failed++;
            $display("FAIL full_release_same grant=%h busy=%b want grant=0 busy=1101", bus.grant, bus.ovc_busy);
        end
        cycle();
        tests_run++;
        if (bus.grant !== (NUM_IVC'(1) << 4) || bus.grant_ovc !== OVC_W'(1) || bus.ovc_busy !== 4'b1111) begin
            tests_failed++;
            $display("FAIL full_regrant grant=%h ovc=%0d busy=%b want grant=%h ovc=1 busy=1111",
                     bus.grant, bus.grant_ovc, bus.ovc_busy, NUM_IVC'(1) << 4);
        end
        bus.req = '0;
    endtask

    task automatic test_credits();
        do_reset();
        bus.req = NUM_IVC'(1);
        cycle();
        bus.req = '0;
        bus.flit_sent = 1'b1; bus.sent_ovc = '0; bus.sent_last = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            cycle();
            tests_run++;
            if (bus.credit[CRED_W-1:0] !== CRED_W'(CREDIT_MAX - n) || bus.err !== 1'b0) begin
                tests_failed++;
                $display("FAIL cred_send%0d cred0=%0d err=%b want cred0=%0d err=0", n, bus.credit[CRED_W-1:0], bus.err, CREDIT_MAX - n);
            end
        end
        cycle();
        tests_run++;
        if (bus.credit[CRED_W-1:0] !== '0 || bus.err !== 1'b1) begin
            tests_failed++;
            $display("FAIL cred_underflow cred0=%0d err=%b want cred0=0 err=1", bus.credit[CRED_W-1:0], bus.err);
        end
        bus.flit_sent = 1'b0; bus.credit_in = 1'b1; bus.credit_ovc = '0;
        cycle(); cycle();
        bus.flit_sent = 1'b1;
        cycle();
        tests_run++;
        if (bus.credit[CRED_W-1:0] !== CRED_W'(2)) begin
            tests_failed++; $display("FAIL cred_send_return cred0=%0d want=2", bus.credit[CRED_W-1:0]);
        end
        idle_inputs();
        do_reset();
        bus.credit_in = 1'b1; bus.credit_ovc = OVC_W'(2);
        cycle();
        bus.credit_in = 1'b0;
        tests_run++;
        if (bus.credit[2*CRED_W +: CRED_W] !== CRED_W'(CREDIT_MAX) || bus.err !== 1'b1) begin
            tests_failed++;
            $display("FAIL cred_overflow cred2=%0d err=%b want cred2=4 err=1", bus.credit[2*CRED_W +: CRED_W], bus.err);
        end
        do_reset();
        bus.flit_sent = 1'b1; bus.sent_ovc = OVC_W'(1);
        cycle();
        bus.flit_sent = 1'b0;
        tests_run++;
        if (bus.credit[CRED_W +: CRED_W] !== CRED_W'(3) || bus.err !== 1'b1 || bus.ovc_busy !== '0) begin
            tests_failed++;
            $display("FAIL send_on_free cred1=%0d err=%b busy=%b want cred1=3 err=1 busy=0000",
                     bus.credit[CRED_W +: CRED_W], bus.err, bus.ovc_busy);
        end
    endtask

`ifdef OVC_DRAIN_CHECK_EN
    task automatic test_drain();
        do_reset();
        bus.req = NUM_IVC'(4'b1111);
        repeat (4) cycle();
        bus.req = '0;
        bus.flit_sent = 1'b1; bus.sent_ovc = '0; bus.sent_last = 1'b1;
        cycle();
        bus.flit_sent = 1'b0; bus.sent_last = 1'b0;
        bus.req = NUM_IVC'(1) << 5;
        repeat (3) begin
            cycle();
            tests_run++;
            if (bus.grant !== '0) begin
                tests_failed++; $display("FAIL drain_wait grant=%h want=0", bus.grant);
            end
        end
        bus.credit_in = 1'b1; bus.credit_ovc = '0;
        cycle();
        bus.credit_in = 1'b0;
        tests_run++;
        if (bus.grant !== '0) begin
            tests_failed++; $display("FAIL drain_return grant=%h want=0", bus.grant);
        end
        cycle();
        tests_run++;
        if (bus.grant !== (NUM_IVC'(1) << 5) || bus.grant_ovc !== '0) begin
            tests_failed++;
            $display("FAIL drain_grant grant=%h ovc=%0d want grant=%h ovc=0", bus.grant, bus.grant_ovc, NUM_IVC'(1) << 5);
        end
        bus.req = '0;
    endtask
`endif

    task automatic test_mid_reset();
        do_reset();
        bus.req = NUM_IVC'(20'h0F0F0);
        cycle(); cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.req = '0;
        tests_run++;
        if (bus.grant !== '0 || bus.ovc_busy !== '0 || bus.grant_ovc !== '0 ||
            bus.credit !== m_cred_vec() || bus.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset grant=%h busy=%b ovc=%0d credit=%h err=%b", bus.grant, bus.ovc_busy,
                     bus.grant_ovc, bus.credit, bus.err);
        end
    endtask

    task automatic test_random();
        int k;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            bus.req = NUM_IVC'($urandom & $urandom);
            k = $urandom_range(0, NUM_OVC - 1);
            bus.sent_ovc  = OVC_W'(k);
            bus.flit_sent = ($urandom_range(0, 1) == 1) &&
                            ((m_busy[k] != 0 && m_cred[k] > 0) || $urandom_range(0, 29) == 0);
            bus.sent_last = ($urandom_range(0, 2) == 0);
            k = $urandom_range(0, NUM_OVC - 1);
            bus.credit_ovc = OVC_W'(k);
            bus.credit_in  = ($urandom_range(0, 1) == 1) &&
                             (m_cred[k] < CREDIT_MAX || $urandom_range(0, 29) == 0);
            cycle();
            tests_run++;
            if (bus.grant !== m_grant || bus.grant_ovc !== OVC_W'(m_gvc) || bus.ovc_busy !== m_busy_vec() ||
                bus.credit !== m_cred_vec() || bus.err !== m_err) begin
                tests_failed++;
                $display("FAIL random c=%0d grant=%h/%h ovc=%0d/%0d busy=%b/%b credit=%h/%h err=%b/%b (got/want)",
                         c, bus.grant, m_grant, bus.grant_ovc, m_gvc, bus.ovc_busy, m_busy_vec(),
                         bus.credit, m_cred_vec(), bus.err, m_err);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_single_hold();
        test_back_to_back();
        test_full_release();
        test_credits();
`ifdef OVC_DRAIN_CHECK_EN
        test_drain();
`endif
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ovc_allocator.md
# ovc_allocator

Per-output-port virtual-channel allocator and credit tracker. It sits directly downstream of the input VC buffers and drives their `grant` and `C` inputs. One instance per router output port:
- arbitrates round-robin among input VCs waiting for an output VC on this port;
- binds each winner to a free output VC until its tail/single flit leaves;
- maintains one downstream credit counter per output VC.

## Interface
Parameters:
- NUM_IVC, 20, number of requesting input VCs (5 ports x 4 VCs)
- IVC_W, 5, width of an input-VC index
- NUM_OVC, 4, output VCs on this port
- OVC_W, 2, width of an output-VC index
- CREDIT_MAX, 4, downstream buffer slots per output VC (credit reset value)
- CRED_W, 3, credit counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NUM_IVC  bit i = input VC i is waiting for an output VC on this port
- grant  out  NUM_IVC  one-hot registered grant pulse, one cycle
- grant_ovc  out  OVC_W  output VC index bound by the current grant
- flit_sent  in  1  a flit left on output VC sent_ovc this cycle
- sent_ovc  in  OVC_W  output VC of flit_sent
- sent_last  in  1  qualifies flit_sent: the flit is tail or single, so the output VC is released
- credit_in  in  1  downstream returned one credit
- credit_ovc  in  OVC_W  output VC of credit_in
- credit  out  NUM_OVC*CRED_W  packed counters, output VC k at [k*CRED_W +: CRED_W]
- ovc_busy  out  NUM_OVC  bit k = output VC k allocated
- err  out  1  sticky: credit underflow/overflow or send on a free output VC

## Operation
- Per output VC k: busy bit, owner index (IVC_W), credit counter.
- Eligibility mask: req[i] is masked when i is the owner of any busy output VC. This prevents a re-grant while a requester is still dropping req.
- Free-VC select: the lowest-index k with busy=0.
- Allocation happens only if an eligible request exists and a free VC exists.
- Arbitration: round-robin pointer rr (IVC_W, reset 0).
  - The winner is the first eligible i searching upward from rr, wrapping at NUM_IVC.
  - On a grant, rr <= winner+1, wrapping to 0 after NUM_IVC-1. rr holds otherwise.
- On allocation at an edge: grant[winner] <= 1, grant_ovc <= k, busy[k] <= 1, owner[k] <= winner.
  - Otherwise grant <= 0; grant_ovc holds its value.
  - At most one grant per cycle.
- Release: flit_sent && sent_last clears busy[sent_ovc] at the edge.
  - That VC is not considered free in the same cycle; it becomes allocatable next cycle.
- Credits, per VC:
  - decrement on flit_sent to that VC;
  - increment on credit_in to that VC;
  - both in the same cycle: unchanged.
- Underflow: a send with credit 0 (and no simultaneous return) leaves the counter at 0 and sets err.
- Overflow: a return with credit CREDIT_MAX (and no simultaneous send) leaves the counter at CREDIT_MAX and sets err.
- flit_sent to a VC with busy=0 sets err; the credit update still applies.
- Reset values: grant 0, grant_ovc 0, ovc_busy 0, every credit = CREDIT_MAX, owners 0, rr 0, err 0.
  - Reset mid-operation drops all bindings immediately; in-flight grants are lost.

## Timing
- req sampled at edge N; grant is visible during cycle N+1 and lasts exactly one cycle.
- The requester may hold req through the grant cycle; the owner mask guarantees no second grant.
- Credit and busy updates are visible on outputs the cycle after the event (registered). There is no combinational path from inputs to outputs.
- Back-to-back grants to different requesters are possible every cycle while free VCs remain.
- A release at edge N makes the VC grantable at edge N+1, so the grant appears in cycle N+2.

## Configuration
- OVC_DRAIN_CHECK_EN defined: a free VC is allocatable only if its credit == CREDIT_MAX, i.e. downstream is fully drained (atomic VC reuse).
  - If no free VC is drained, no grant is issued and requests wait.
- Undefined: any VC with busy=0 is allocatable regardless of credit.

## Test plan
- Reset, then idle 3 cycles -> grant=0, ovc_busy=0, each credit field=4, err=0.
- req=bit3 held -> grant=bit3 and grant_ovc=0 one cycle later, ovc_busy=0001, no further grant while req held.
- req bits 2,5,7 asserted together with rr=0 -> grants 2, 5, 7 on consecutive cycles on OVCs 0, 1, 2, then rr=8.
- All 4 VCs busy plus a fifth request; release OVC 1 with sent_last -> fifth requester granted grant_ovc=1 two cycles after release.
- 4 sends on OVC 0 -> credit 0; a fifth send -> credit stays 0, err=1; a simultaneous send+return at credit 2 -> stays 2.
- With OVC_DRAIN_CHECK_EN: OVC 0 released at credit 3 and the only free VC -> no grant until credit returns to 4, then grant next cycle.
